// File: rtl/uxn_pkg.sv
// Shared definitions for the uxn ALU and its working-stack sequencer.
package uxn_pkg;

    localparam int unsigned STACK_AW = 8;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_DIV = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SFT = 4'd7
    } alu_ops;

    typedef enum logic [1:0] {
        CMD_PUSH = 2'b00,
        CMD_POP  = 2'b01,
        CMD_ALU  = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_kind_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_t;

endpackage

// File: rtl/stack_ram.sv
// 256x8 working-stack storage: one synchronous read port, one write port, no reset.
module stack_ram
    import uxn_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [STACK_AW-1:0] waddr,
    input  logic [7:0]          wdata,
    input  logic [STACK_AW-1:0] raddr,
    output logic [7:0]          rdata
);
    localparam int unsigned ENTRIES = 1 << STACK_AW;

    logic [7:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/alu_stack_sequencer.sv
// Working-stack front end for the 8-bit ALU: PUSH/POP/ALU commands in, one
// response pulse per command out, operands and result moved through stack_ram.
module alu_stack_sequencer
    import uxn_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_kind,
    input  logic [3:0] cmd_alu_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic [3:0] alu_operation,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic [1:0] rsp_err,
    output logic [8:0] depth
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = STACK_AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH_WR, S_POP_RD, S_RSP, S_RD_B, S_RD_A, S_EXEC, S_WB, S_ERR
    } state_t;

    state_t              state, state_d;
    logic [STACK_AW-1:0] sp, sp_d;
    logic [CW-1:0]       depth_d;
    logic [DW-1:0]       data_q, data_d;
    logic [3:0]          op_q, op_d;
    logic [DW-1:0]       alu_op1_d, alu_op2_d;
    logic [3:0]          alu_operation_d;
    logic                rsp_valid_d, rsp_carry_d, rsp_zero_d;
    logic [DW-1:0]       rsp_data_d;
    err_t                rsp_err_d;

    logic                ram_we_c;
    logic [STACK_AW-1:0] ram_waddr_c, ram_raddr_c;
    logic [DW-1:0]       ram_wdata_c, ram_rdata;

    stack_ram u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .raddr (ram_raddr_c),
        .rdata (ram_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            sp            <= '0;
            depth         <= '0;
            data_q        <= '0;
            op_q          <= '0;
            cmd_ready     <= 1'b0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_operation <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_carry     <= 1'b0;
            rsp_zero      <= 1'b0;
            rsp_err       <= '0;
        end else begin
            state         <= state_d;
            sp            <= sp_d;
            depth         <= depth_d;
            data_q        <= data_d;
            op_q          <= op_d;
            cmd_ready     <= (state_d == S_IDLE);
            alu_op1       <= alu_op1_d;
            alu_op2       <= alu_op2_d;
            alu_operation <= alu_operation_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
            rsp_carry     <= rsp_carry_d;
            rsp_zero      <= rsp_zero_d;
            rsp_err       <= rsp_err_d;
        end
    end

    // Next state, next outputs and RAM port control. The top of stack is read
    // speculatively while idle so POP data and operand b arrive one cycle after accept.
    always_comb begin
        state_d         = state;
        sp_d            = sp;
        depth_d         = depth;
        data_d          = data_q;
        op_d            = op_q;
        alu_op1_d       = alu_op1;
        alu_op2_d       = alu_op2;
        alu_operation_d = alu_operation;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data;
        rsp_carry_d     = rsp_carry;
        rsp_zero_d      = rsp_zero;
        rsp_err_d       = err_t'(rsp_err);
        ram_we_c        = 1'b0;
        ram_waddr_c     = sp;
        ram_wdata_c     = data_q;
        ram_raddr_c     = sp - STACK_AW'(1);

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    data_d      = cmd_data;
                    op_d        = cmd_alu_op;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                    rsp_zero_d  = 1'b0;
                    rsp_err_d   = ERR_OK;
                    state_d     = S_ERR;
                    case (cmd_kind_t'(cmd_kind))
                        CMD_PUSH: begin
                            if (depth == FULL) begin
                                rsp_err_d = ERR_OVERFLOW;
                            end else begin
                                state_d    = S_PUSH_WR;
                                rsp_data_d = cmd_data;
                            end
                        end
                        CMD_POP: begin
                            if (depth == '0) begin
                                rsp_err_d = ERR_UNDERFLOW;
                            end else begin
                                state_d     = S_POP_RD;
                                rsp_valid_d = 1'b0;
                            end
                        end
                        CMD_ALU: begin
                            if (depth < CW'(2)) begin
                                rsp_err_d = ERR_UNDERFLOW;
                            end else if (cmd_alu_op > 4'(ALU_SFT)) begin
                                rsp_err_d = ERR_ILLEGAL;
                            end else begin
                                state_d     = S_RD_B;
                                rsp_valid_d = 1'b0;
                            end
                        end
                        default: rsp_err_d = ERR_ILLEGAL;
                    endcase
                end
            end
            S_PUSH_WR: begin
                ram_we_c = ~rst;
                sp_d     = sp + STACK_AW'(1);
                depth_d  = depth + CW'(1);
                state_d  = S_IDLE;
            end
            S_POP_RD: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = ram_rdata;
                rsp_carry_d = 1'b0;
                rsp_zero_d  = 1'b0;
                rsp_err_d   = ERR_OK;
                state_d     = S_RSP;
            end
            S_RSP: begin
                sp_d    = sp - STACK_AW'(1);
                depth_d = depth - CW'(1);
                state_d = S_IDLE;
            end
            S_RD_B: begin
                alu_op2_d   = ram_rdata;
                ram_raddr_c = sp - STACK_AW'(2);
                state_d     = S_RD_A;
            end
            S_RD_A: begin
                alu_op1_d       = ram_rdata;
                alu_operation_d = op_q;
                state_d         = S_EXEC;
            end
            S_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_result;
                rsp_carry_d = alu_carry;
                rsp_zero_d  = alu_zero;
                rsp_err_d   = ERR_OK;
                state_d     = S_WB;
            end
            S_WB: begin
                ram_we_c    = ~rst;
                ram_waddr_c = sp - STACK_AW'(2);
                ram_wdata_c = rsp_data;
                sp_d        = sp - STACK_AW'(1);
                depth_d     = depth - CW'(1);
                state_d     = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Directed bench for alu_stack_sequencer: queue-based stack model, behavioural ALU,
// and a negedge compare process checking every response against the model.
module tb_alu_stack_sequencer;
    import uxn_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [3:0] cmd_alu_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_op1, alu_op2;
    logic [3:0] alu_operation;
    logic [7:0] alu_result;
    logic       alu_carry, alu_zero;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_carry, rsp_zero;
    logic [1:0] rsp_err;
    logic [8:0] depth;

    alu_stack_sequencer #(.DEPTH(256)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_kind      (cmd_kind),
        .cmd_alu_op    (cmd_alu_op),
        .cmd_data      (cmd_data),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_zero      (alu_zero),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
        .rsp_err       (rsp_err),
        .depth         (depth)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: {carry, result}
    function automatic logic [8:0] alu_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        case (op)
            4'd0: return 9'(a) + 9'(b);
            4'd1: return 9'(a) - 9'(b);
            4'd2: begin
                p = 16'(a) * 16'(b);
                return {|p[15:8], p[7:0]};
            end
            4'd3: return (b == 8'h00) ? 9'h000 : {1'b0, a / b};
            4'd4: return {1'b0, a & b};
            4'd5: return {1'b0, a | b};
            4'd6: return {1'b0, a ^ b};
            4'd7: return {1'b0, 8'((a >> b[3:0]) << b[7:4])};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_calc(alu_operation, alu_op1, alu_op2);
    assign alu_zero = (alu_result == 8'h00);

    typedef struct {
        logic [7:0] data;
        logic       chk_data;
        logic       c;
        logic       z;
        logic [1:0] err;
        int         lat;
        longint     t;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stk[$];
    logic [7:0] sp_m = 8'h00;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_data;
    logic       last_c, last_z;
    logic [1:0] last_err;
    longint     accept_t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event, expected orderly handshake at t=%0t", name, $time);
    endtask

    // Compare process: operands during EXEC, response contents and latency
    always @(negedge clk) begin
        longint dt;
        exp_t   cur;
        dt = 0;
        if (exp_q.size() != 0) begin
            dt = longint'($time) - exp_q[0].t;
            if (exp_q[0].lat == 4 && dt == 25) begin
                chk("exec_alu_op1", 32'(alu_op1), 32'(exp_q[0].a));
                chk("exec_alu_op2", 32'(alu_op2), 32'(exp_q[0].b));
                chk("exec_alu_operation", 32'(alu_operation), 32'(exp_q[0].op));
            end
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                cur = exp_q.pop_front();
                chk("rsp_latency", 32'(dt), 32'((cur.lat - 1) * 10 + 5));
                chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                if (cur.chk_data) begin
                    chk("rsp_data", 32'(rsp_data), 32'(cur.data));
                    chk("rsp_carry", 32'(rsp_carry), 32'(cur.c));
                    chk("rsp_zero", 32'(rsp_zero), 32'(cur.z));
                end
                last_data = rsp_data;
                last_c    = rsp_carry;
                last_z    = rsp_zero;
                last_err  = rsp_err;
            end
        end else if (exp_q.size() != 0 && dt > longint'((exp_q[0].lat - 1) * 10 + 5)) begin
            fail("rsp_missing");
            void'(exp_q.pop_front());
        end
    end

    // Issue one command at a negedge; update the model at the accept edge
    task automatic send(input logic [1:0] kind, input logic [3:0] op, input logic [7:0] data);
        int         n = 0;
        exp_t       e;
        logic [7:0] a, b;
        logic [8:0] r;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail("cmd_ready_timeout");
            return;
        end
        cmd_kind   = kind;
        cmd_alu_op = op;
        cmd_data   = data;
        cmd_valid  = 1'b1;
        @(posedge clk);
        accept_t   = longint'($time);
        e          = '{default: 0};
        e.t        = longint'($time);
        e.lat      = 1;
        e.chk_data = 1'b1;
        case (kind)
            2'b00: begin
                if (stk.size() == 256) begin
                    e.err = 2'b10; e.chk_data = 1'b0;
                end else begin
                    stk.push_back(data); e.data = data; sp_m = sp_m + 8'd1;
                end
            end
            2'b01: begin
                if (stk.size() == 0) begin
                    e.err = 2'b01; e.chk_data = 1'b0;
                end else begin
                    e.data = stk.pop_back(); e.lat = 2; sp_m = sp_m - 8'd1;
                end
            end
            2'b10: begin
                if (stk.size() < 2) begin
                    e.err = 2'b01; e.chk_data = 1'b0;
                end else if (op > 4'd7) begin
                    e.err = 2'b11; e.chk_data = 1'b0;
                end else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    r = alu_calc(op, a, b);
                    stk.push_back(r[7:0]);
                    e.data = r[7:0]; e.c = r[8]; e.z = (r[7:0] == 8'h00);
                    e.lat = 4; e.a = a; e.b = b; e.op = op;
                    sp_m = sp_m - 8'd1;
                end
            end
            default: begin
                e.err = 2'b11; e.chk_data = 1'b0;
            end
        endcase
        exp_q.push_back(e);
        #1 cmd_valid = 1'b0;
    endtask

    // Wait for the response to drain and the block to be ready again
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || !cmd_ready) && n < 50);
        if (n >= 50) fail("done_timeout");
        else chk("depth", 32'(depth), 32'(stk.size()));
    endtask

    task automatic cmd(input logic [1:0] kind, input logic [3:0] op, input logic [7:0] data);
        send(kind, op, data);
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before t=100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint prev_t;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_kind   = 2'b00;
        cmd_alu_op = 4'd0;
        cmd_data   = 8'h00;

        // Reset held for three edges
        repeat (3) begin
            @(negedge clk);
            chk("reset_ready", 32'(cmd_ready), 32'(0));
            chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(cmd_ready), 32'(1));
        chk("post_reset_depth", 32'(depth), 32'(0));
        chk("post_reset_rsp_data", 32'(rsp_data), 32'(0));
        chk("post_reset_alu_op1", 32'(alu_op1), 32'(0));

        // a b SUB gives a-b
        cmd(2'b00, 4'd0, 8'h12);
        cmd(2'b00, 4'd0, 8'h05);
        cmd(2'b10, 4'(ALU_SUB), 8'h00);
        chk("sub_lit_data", 32'(last_data), 32'h0D);
        chk("sub_lit_err", 32'(last_err), 32'(0));
        chk("sub_lit_depth", 32'(depth), 32'(1));
        cmd(2'b01, 4'd0, 8'h00);
        chk("sub_pop_lit", 32'(last_data), 32'h0D);

        // ADD with carry, then XOR to zero
        cmd(2'b00, 4'd0, 8'hF0);
        cmd(2'b00, 4'd0, 8'h20);
        cmd(2'b10, 4'(ALU_ADD), 8'h00);
        chk("add_lit_data", 32'(last_data), 32'h10);
        chk("add_lit_carry", 32'(last_c), 32'(1));
        chk("add_lit_zero", 32'(last_z), 32'(0));
        cmd(2'b00, 4'd0, 8'h10);
        cmd(2'b10, 4'(ALU_XOR), 8'h00);
        chk("xor_lit_data", 32'(last_data), 32'h00);
        chk("xor_lit_zero", 32'(last_z), 32'(1));
        cmd(2'b10, 4'(ALU_MUL), 8'h00);
        chk("alu_depth1_err", 32'(last_err), 32'(1));
        chk("alu_depth1_depth", 32'(depth), 32'(1));
        cmd(2'b01, 4'd0, 8'h00);
        cmd(2'b01, 4'd0, 8'h00);
        chk("pop_empty_err", 32'(last_err), 32'(1));
        cmd(2'b11, 4'd0, 8'h00);
        chk("reserved_err", 32'(last_err), 32'(3));

        // Illegal opcode with enough operands, then MUL/DIV/SFT through the model
        cmd(2'b00, 4'd0, 8'h21);
        cmd(2'b00, 4'd0, 8'h13);
        cmd(2'b10, 4'd9, 8'h00);
        chk("illegal_op_err", 32'(last_err), 32'(3));
        chk("illegal_op_depth", 32'(depth), 32'(2));
        cmd(2'b10, 4'(ALU_MUL), 8'h00);
        cmd(2'b00, 4'd0, 8'h07);
        cmd(2'b10, 4'(ALU_DIV), 8'h00);
        cmd(2'b00, 4'd0, 8'h12);
        cmd(2'b10, 4'(ALU_SFT), 8'h00);
        cmd(2'b01, 4'd0, 8'h00);

        // Fill to 256, wrap sp, overflow, then pop the last pushed value
        prev_t = 0;
        for (int i = 0; i < 256; i++) begin
            send(2'b00, 4'd0, 8'(i));
            if (i == 1) chk("push_throughput", 32'(accept_t - prev_t), 32'(20));
            prev_t = accept_t;
            wait_done();
        end
        chk("full_depth", 32'(depth), 32'(256));
        chk("sp_wrap", 32'(dut.sp), 32'(sp_m));
        cmd(2'b00, 4'd0, 8'hAA);
        chk("overflow_err", 32'(last_err), 32'(2));
        cmd(2'b01, 4'd0, 8'h00);
        chk("pop_after_full_lit", 32'(last_data), 32'hFF);

        // Reset during EXEC aborts the ALU command
        send(2'b10, 4'(ALU_ADD), 8'h00);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        stk.delete();
        sp_m = 8'h00;
        repeat (2) begin
            @(negedge clk);
            chk("midop_reset_ready", 32'(cmd_ready), 32'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midop_post_ready", 32'(cmd_ready), 32'(1));
        chk("midop_post_depth", 32'(depth), 32'(0));
        repeat (3) @(negedge clk);
        cmd(2'b00, 4'd0, 8'h3C);
        cmd(2'b01, 4'd0, 8'h00);
        chk("after_reset_pop_lit", 32'(last_data), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_stack_sequencer.md
# alu_stack_sequencer

Working-stack front end for the 8-bit ALU, sitting directly upstream of it. It accepts push, pop and ALU commands over a valid/ready handshake and holds a 256-byte working stack. For ALU commands it pops two operands, drives them to the combinational ALU, and writes the result back as the new top of stack. Each command produces a single-cycle response carrying data, flags and an error code.

## Interface
Parameters:
- `DEPTH`, default 256: stack entries. The implementation supports only 256, so the stack pointer is 8 bits and the depth counter is 9 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block can accept a command.
- `cmd_kind` in 2: 00 PUSH, 01 POP, 10 ALU, 11 reserved.
- `cmd_alu_op` in 4: ALU operation code, 0..7 (ADD SUB MUL DIV AND OR XOR SFT).
- `cmd_data` in 8: literal for PUSH.
- `alu_op1` out 8: second-from-top operand, to the ALU.
- `alu_op2` out 8: top-of-stack operand, to the ALU.
- `alu_operation` out 4: operation code, to the ALU.
- `alu_result` in 8, `alu_carry` in 1, `alu_zero` in 1: combinational returns from the ALU.
- `rsp_valid` out 1: one-cycle response pulse. There is no backpressure.
- `rsp_data` out 8: popped value or ALU result.
- `rsp_carry` out 1, `rsp_zero` out 1: ALU flags. Both are 0 for PUSH/POP.
- `rsp_err` out 2: 00 OK, 01 UNDERFLOW, 10 OVERFLOW, 11 ILLEGAL.
- `depth` out 9: current entry count, 0..256.

## Operation
- The handshake completes on a rising edge where `cmd_valid & cmd_ready`. All command fields are captured at that edge.
- `cmd_ready` is 1 only in IDLE.
- Stack layout: `sp` is 8 bits and points to the next free slot, so the top of stack is `mem[sp-1]`. `sp` wraps modulo 256. `depth` guards against overflow and underflow; the wrap itself is never an error.
- Operand order follows uxn: `a b OP`, with b on top. `alu_op1=a` and `alu_op2=b`, so SUB gives a-b.
- PUSH:
  - If depth==256: respond OVERFLOW; no state change.
  - Otherwise: write `cmd_data` to `mem[sp]`, then sp+1 and depth+1. `rsp_data` = the pushed value.
- POP:
  - If depth==0: respond UNDERFLOW.
  - Otherwise: read `mem[sp-1]`, then sp-1 and depth-1. `rsp_data` = the value read.
- ALU:
  - If depth<2: respond UNDERFLOW; no state change.
  - If `cmd_alu_op` > 7: respond ILLEGAL; no state change.
  - Otherwise: read b, then a, drive the ALU, and write the result to `mem[sp-2]`. Then sp-1 and depth-1.
  - The response carries the result, carry and zero.
- Reserved `cmd_kind` (11): respond ILLEGAL; no state change.
- FSM states:
  - IDLE → PUSH_WR | POP_RD | RD_B | ERR.
  - RD_B → RD_A → EXEC → WB → IDLE.
  - POP_RD → RSP → IDLE.
  - PUSH_WR → IDLE. The response is driven from the PUSH_WR cycle.
  - ERR → IDLE.
- `alu_op1`, `alu_op2` and `alu_operation` are registered and held stable throughout EXEC. `alu_result`, `alu_carry` and `alu_zero` are sampled at the end of EXEC.
- Reset values: `cmd_ready`=0 while `rst` is high and 1 in the first cycle after; `rsp_valid`=0; `rsp_data`=0; `rsp_carry`=0; `rsp_zero`=0; `rsp_err`=0; `alu_op1`=0; `alu_op2`=0; `alu_operation`=0; `depth`=0; `sp`=0; FSM in IDLE.
- Reset mid-operation aborts the command: no response, no write-back, `sp`=0, `depth`=0. Memory contents are not cleared.

## Timing
- The memory has synchronous read with one-cycle latency and write-first-free timing: a write and a read to different addresses may occur in the same cycle.
- Latency from the accept edge to the `rsp_valid` cycle:
  - PUSH: 1 cycle.
  - POP: 2 cycles.
  - ALU: 4 cycles (RD_B, RD_A, EXEC, WB; `rsp_valid` is high in WB).
  - Error: 1 cycle.
- `cmd_ready` returns to 1 in the cycle after `rsp_valid`.
- Throughput in back-to-back PUSH: one command every 2 cycles.
- `depth` and `sp` update on the same edge that ends the response cycle.

## Structure
- Shared package `uxn_pkg` holds:
  - the `alu_ops` enum (moved out of the ALU so that both blocks import it);
  - the `cmd_kind_t` and `err_t` enums;
  - the `STACK_AW=8` constant.
- The FSM state enum stays local to the module.
- One sub-module, `stack_ram`: 256x8, one synchronous read port and one write port, no reset.
- The ALU is instantiated at the parent level, not inside this block.

## Test plan
- Reset held 3 cycles: `cmd_ready`=0 during reset, 1 in the first cycle after; `depth`=0; `rsp_valid` never pulses.
- PUSH 0x12, PUSH 0x05, ALU SUB: during EXEC `alu_op1`=0x12 and `alu_op2`=0x05. Response: data 0x0D, err 00, `depth` 1; the following POP returns 0x0D.
- PUSH 0xF0, PUSH 0x20, ALU ADD: data 0x10, carry 1, zero 0. Then PUSH 0x10, ALU XOR: data 0x00, zero 1.
- Underflow and illegal cases, each with no state change:
  - ALU with depth 1: err 01, `depth` stays 1.
  - POP on empty stack: err 01.
  - `cmd_kind`=11: err 11.
- 256 PUSHes of i&0xFF: `depth`=256 and `sp` has wrapped to 0. The 257th PUSH gets err 10. POP then returns 0xFF.
- ALU ADD with `rst` asserted during EXEC: no `rsp_valid`, `depth`=0 and `cmd_ready`=1 after reset; the next PUSH/POP behaves normally.
